fetch_stage: RTL and testbench

//  Instruction fetch stage of the pipelined RV32 core; upstream of decode.

---
 rtl/riscv_pkg.sv | 14 +
 rtl/fetch_hold_buf.sv | 39 +++
 rtl/fetch_stage.sv | 159 +++++++++++++++
 tb/tb_fetch_stage.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared definitions for the RV32 pipeline: the canonical NOP encoding and the
// fetch-stage state type.
package riscv_pkg;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_hold_buf.sv
// One-entry skid register for the fetch stage. It parks an instruction that
// came back from imem while decode was stalled, so the word is never re-fetched.
module fetch_hold_buf
    import riscv_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int PC_WIDTH   = 10
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  load,
    input  logic                  clear,
    input  logic [DATA_WIDTH-1:0] d_instr,
    input  logic [PC_WIDTH-1:0]   d_pc,
    input  logic [PC_WIDTH-1:0]   d_pc4,
    output logic [DATA_WIDTH-1:0] q_instr,
    output logic [PC_WIDTH-1:0]   q_pc,
    output logic [PC_WIDTH-1:0]   q_pc4,
    output logic                  full
);

    // Capture the triple on load; clear only empties, the stale payload is harmless.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            full    <= 1'b0;
            q_instr <= DATA_WIDTH'(NOP_INSTR);
            q_pc    <= '0;
            q_pc4   <= '0;
        end else if (clear) begin
            full <= 1'b0;
        end else if (load) begin
            full    <= 1'b1;
            q_instr <= d_instr;
            q_pc    <= d_pc;
            q_pc4   <= d_pc4;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// RV32 instruction fetch stage: PC register, single-outstanding imem port,
// redirect/kill handling and the IF/ID pipeline register feeding decode.
module fetch_stage
    import riscv_pkg::*;
#(
    parameter int                   DATA_WIDTH = 32,
    parameter int                   PC_WIDTH   = 10,
    parameter logic [PC_WIDTH-1:0]  RESET_PC   = '0
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_stall_d,
    input  logic                  i_flush_d,
    input  logic                  i_pcsrc_e,
    input  logic [PC_WIDTH-1:0]   i_pc_target_e,
    output logic                  o_imem_req,
    output logic [PC_WIDTH-1:0]   o_imem_addr,
    input  logic                  i_imem_rvalid,
    input  logic [DATA_WIDTH-1:0] i_imem_rdata,
    output logic [DATA_WIDTH-1:0] o_instr_d,
    output logic [PC_WIDTH-1:0]   o_pc_d,
    output logic [PC_WIDTH-1:0]   o_pc4_d,
    output logic                  o_valid_d
);

    fetch_state_t          state;
    logic [PC_WIDTH-1:0]   pc_f;
    logic [PC_WIDTH-1:0]   pc_f4;
    logic [PC_WIDTH-1:0]   target_al;
    logic                  kill;

    logic                  wait_hit;
    logic                  wait_good;
    logic                  deliver_mem;
    logic                  deliver_hold;
    logic                  hold_load;
    logic                  hold_drop;
    logic                  deliver;

    logic [DATA_WIDTH-1:0] hb_instr;
    logic [PC_WIDTH-1:0]   hb_pc;
    logic [PC_WIDTH-1:0]   hb_pc4;
    logic                  hb_full;

    logic [DATA_WIDTH-1:0] new_instr;
    logic [PC_WIDTH-1:0]   new_pc;
    logic [PC_WIDTH-1:0]   new_pc4;

    // Wraps modulo 2^PC_WIDTH by construction.
    assign pc_f4     = pc_f + PC_WIDTH'(4);
    assign target_al = {i_pc_target_e[PC_WIDTH-1:2], 2'b00};

    // A response is usable only if no redirect made it wrong-path.
    assign wait_hit     = (state == S_WAIT) && i_imem_rvalid;
    assign wait_good    = wait_hit && !kill && !i_pcsrc_e;
    assign deliver_mem  = wait_good && !i_stall_d;
    assign hold_load    = wait_good && i_stall_d;
    assign deliver_hold = (state == S_HOLD) && hb_full && !i_pcsrc_e && !i_stall_d;
    assign hold_drop    = (state == S_HOLD) && i_pcsrc_e;
    assign deliver      = deliver_mem || deliver_hold;

    assign new_instr = deliver_hold ? hb_instr : i_imem_rdata;
    assign new_pc    = deliver_hold ? hb_pc    : pc_f;
    assign new_pc4   = deliver_hold ? hb_pc4   : pc_f4;

    // State already sits at S_REQ during reset, so the strobe is gated by reset
    // to keep imem quiet until release; the first request goes out right after.
    assign o_imem_req  = (state == S_REQ) && !i_rst;
    assign o_imem_addr = pc_f;

    fetch_hold_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .PC_WIDTH   (PC_WIDTH)
    ) u_hold (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .load    (hold_load),
        .clear   (deliver_hold || hold_drop),
        .d_instr (i_imem_rdata),
        .d_pc    (pc_f),
        .d_pc4   (pc_f4),
        .q_instr (hb_instr),
        .q_pc    (hb_pc),
        .q_pc4   (hb_pc4),
        .full    (hb_full)
    );

    // Fetch FSM with PC and kill tracking; a redirect always wins over delivery.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= S_REQ;
            pc_f  <= RESET_PC;
            kill  <= 1'b0;
        end else begin
            case (state)
                S_REQ: begin
                    state <= S_WAIT;
                    if (i_pcsrc_e) begin
                        pc_f <= target_al;
                        kill <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (i_imem_rvalid) begin
                        kill <= 1'b0;
                        if (kill || i_pcsrc_e) begin
                            state <= S_REQ;
                            if (i_pcsrc_e) pc_f <= target_al;
                        end else if (!i_stall_d) begin
                            state <= S_REQ;
                            pc_f  <= pc_f4;
                        end else begin
                            state <= S_HOLD;
                        end
                    end else if (i_pcsrc_e) begin
                        pc_f <= target_al;
                        kill <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (i_pcsrc_e) begin
                        state <= S_REQ;
                        pc_f  <= target_al;
                    end else if (!i_stall_d) begin
                        state <= S_REQ;
                        pc_f  <= pc_f4;
                    end
                end
                default: state <= S_REQ;
            endcase
        end
    end

    // IF/ID register: flush beats stall beats a new instruction; else a bubble.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_instr_d <= DATA_WIDTH'(NOP_INSTR);
            o_pc_d    <= '0;
            o_pc4_d   <= '0;
            o_valid_d <= 1'b0;
        end else if (i_flush_d) begin
            o_instr_d <= DATA_WIDTH'(NOP_INSTR);
            o_pc_d    <= '0;
            o_pc4_d   <= '0;
            o_valid_d <= 1'b0;
        end else if (i_stall_d) begin
            o_valid_d <= o_valid_d;
        end else if (deliver) begin
            o_instr_d <= new_instr;
            o_pc_d    <= new_pc;
            o_pc4_d   <= new_pc4;
            o_valid_d <= 1'b1;
        end else begin
            o_instr_d <= DATA_WIDTH'(NOP_INSTR);
            o_valid_d <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a latency-programmable imem responder.
module tb_fetch_stage;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_stall_d;
    logic        i_flush_d;
    logic        i_pcsrc_e;
    logic [9:0]  i_pc_target_e;
    logic        o_imem_req;
    logic [9:0]  o_imem_addr;
    logic        i_imem_rvalid;
    logic [31:0] i_imem_rdata;
    logic [31:0] o_instr_d;
    logic [9:0]  o_pc_d;
    logic [9:0]  o_pc4_d;
    logic        o_valid_d;

    int checks = 0;
    int errors = 0;
    int mem_lat = 1;

    logic [9:0] addr_q;
    int         cnt;
    logic       pend;

    always #5 i_clk = ~i_clk;

    fetch_stage dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_stall_d     (i_stall_d),
        .i_flush_d     (i_flush_d),
        .i_pcsrc_e     (i_pcsrc_e),
        .i_pc_target_e (i_pc_target_e),
        .o_imem_req    (o_imem_req),
        .o_imem_addr   (o_imem_addr),
        .i_imem_rvalid (i_imem_rvalid),
        .i_imem_rdata  (i_imem_rdata),
        .o_instr_d     (o_instr_d),
        .o_pc_d        (o_pc_d),
        .o_pc4_d       (o_pc4_d),
        .o_valid_d     (o_valid_d)
    );

    function automatic logic [31:0] mem_word(input logic [9:0] a);
        if (a == 10'h000) return 32'h0050_0093;
        return 32'hA500_0000 | {22'd0, a};
    endfunction

    // imem model: answers mem_lat cycles after the request; reset drops it.
    always @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            pend          <= 1'b0;
            cnt           <= 0;
            addr_q        <= '0;
            i_imem_rvalid <= 1'b0;
            i_imem_rdata  <= '0;
        end else begin
            i_imem_rvalid <= 1'b0;
            if (o_imem_req) begin
                if (mem_lat <= 1) begin
                    i_imem_rvalid <= 1'b1;
                    i_imem_rdata  <= mem_word(o_imem_addr);
                end else begin
                    pend   <= 1'b1;
                    cnt    <= mem_lat - 1;
                    addr_q <= o_imem_addr;
                end
            end else if (pend) begin
                if (cnt == 1) begin
                    i_imem_rvalid <= 1'b1;
                    i_imem_rdata  <= mem_word(addr_q);
                    pend          <= 1'b0;
                end else begin
                    cnt <= cnt - 1;
                end
            end
        end
    end

    task automatic step();
        @(negedge i_clk);
    endtask

    task automatic test_reset();
        i_rst = 1'b1; i_stall_d = 1'b0; i_flush_d = 1'b0; i_pcsrc_e = 1'b0; i_pc_target_e = '0;
        step(); step();
        checks++; if (o_imem_req !== 1'b0) begin errors++; $display("FAIL rst_req got %0b exp 0", o_imem_req); end
        checks++; if ({o_instr_d, o_pc_d, o_pc4_d, o_valid_d} !== {32'h0000_0013, 10'h000, 10'h000, 1'b0}) begin errors++; $display("FAIL rst_ifid got %h exp %h", {o_instr_d, o_pc_d, o_pc4_d, o_valid_d}, {32'h0000_0013, 10'h000, 10'h000, 1'b0}); end
        i_rst = 1'b0;
        #1;
        checks++; if ({o_imem_req, o_imem_addr} !== {1'b1, 10'h000}) begin errors++; $display("FAIL rel_req got %h exp %h", {o_imem_req, o_imem_addr}, {1'b1, 10'h000}); end
    endtask

    task automatic test_first_fetch();
        step();
        checks++; if ({o_imem_req, o_valid_d} !== 2'b00) begin errors++; $display("FAIL ff_wait got %b exp 00", {o_imem_req, o_valid_d}); end
        step();
        checks++; if ({o_instr_d, o_pc_d, o_pc4_d, o_valid_d} !== {32'h0050_0093, 10'h000, 10'h004, 1'b1}) begin errors++; $display("FAIL ff_ifid got %h exp %h", {o_instr_d, o_pc_d, o_pc4_d, o_valid_d}, {32'h0050_0093, 10'h000, 10'h004, 1'b1}); end
        checks++; if ({o_imem_req, o_imem_addr} !== {1'b1, 10'h004}) begin errors++; $display("FAIL ff_next_req got %h exp %h", {o_imem_req, o_imem_addr}, {1'b1, 10'h004}); end
    endtask

    task automatic test_stall();
        i_stall_d = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if ({o_instr_d, o_pc_d, o_pc4_d, o_valid_d, o_imem_req} !== {32'h0050_0093, 10'h000, 10'h004, 1'b1, 1'b0}) begin errors++; $display("FAIL stall_hold%0d got %h exp %h", i, {o_instr_d, o_pc_d, o_pc4_d, o_valid_d, o_imem_req}, {32'h0050_0093, 10'h000, 10'h004, 1'b1, 1'b0}); end
        end
        i_stall_d = 1'b0;
        step();
        checks++; if ({o_instr_d, o_pc_d, o_pc4_d, o_valid_d} !== {32'hA500_0004, 10'h004, 10'h008, 1'b1}) begin errors++; $display("FAIL stall_release got %h exp %h", {o_instr_d, o_pc_d, o_pc4_d, o_valid_d}, {32'hA500_0004, 10'h004, 10'h008, 1'b1}); end
        checks++; if ({o_imem_req, o_imem_addr} !== {1'b1, 10'h008}) begin errors++; $display("FAIL stall_next_req got %h exp %h", {o_imem_req, o_imem_addr}, {1'b1, 10'h008}); end
        step();
        checks++; if ({o_instr_d, o_pc_d, o_pc4_d, o_valid_d} !== {32'h0000_0013, 10'h004, 10'h008, 1'b0}) begin errors++; $display("FAIL stall_no_dup got %h exp %h", {o_instr_d, o_pc_d, o_pc4_d, o_valid_d}, {32'h0000_0013, 10'h004, 10'h008, 1'b0}); end
        step();
        checks++; if ({o_instr_d, o_pc_d, o_pc4_d, o_valid_d} !== {32'hA500_0008, 10'h008, 10'h00C, 1'b1}) begin errors++; $display("FAIL stall_after got %h exp %h", {o_instr_d, o_pc_d, o_pc4_d, o_valid_d}, {32'hA500_0008, 10'h008, 10'h00C, 1'b1}); end
    endtask

    task automatic test_redirect_wait();
        mem_lat = 3;
        step();
        i_pcsrc_e = 1'b1; i_pc_target_e = 10'h040;
        step();
        i_pcsrc_e = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++; if ({o_imem_req, o_valid_d} !== 2'b00) begin errors++; $display("FAIL rw_wait%0d got %b exp 00", i, {o_imem_req, o_valid_d}); end
            step();
        end
        checks++; if ({o_imem_req, o_imem_addr, o_valid_d} !== {1'b1, 10'h040, 1'b0}) begin errors++; $display("FAIL rw_req got %h exp %h", {o_imem_req, o_imem_addr, o_valid_d}, {1'b1, 10'h040, 1'b0}); end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (o_valid_d !== 1'b0) begin errors++; $display("FAIL rw_bubble%0d got %0b exp 0", i, o_valid_d); end
        end
        step();
        checks++; if ({o_instr_d, o_pc_d, o_pc4_d, o_valid_d} !== {32'hA500_0040, 10'h040, 10'h044, 1'b1}) begin errors++; $display("FAIL rw_ifid got %h exp %h", {o_instr_d, o_pc_d, o_pc4_d, o_valid_d}, {32'hA500_0040, 10'h040, 10'h044, 1'b1}); end
    endtask

    task automatic test_redirect_req();
        checks++; if ({o_imem_req, o_imem_addr} !== {1'b1, 10'h044}) begin errors++; $display("FAIL rr_pre got %h exp %h", {o_imem_req, o_imem_addr}, {1'b1, 10'h044}); end
        i_pcsrc_e = 1'b1; i_pc_target_e = 10'h081;
        step();
        i_pcsrc_e = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++; if ({o_imem_req, o_valid_d} !== 2'b00) begin errors++; $display("FAIL rr_wait%0d got %b exp 00", i, {o_imem_req, o_valid_d}); end
            step();
        end
        checks++; if ({o_imem_req, o_imem_addr, o_valid_d} !== {1'b1, 10'h080, 1'b0}) begin errors++; $display("FAIL rr_req got %h exp %h", {o_imem_req, o_imem_addr, o_valid_d}, {1'b1, 10'h080, 1'b0}); end
        mem_lat = 1;
        step(); step();
        checks++; if ({o_instr_d, o_pc_d, o_pc4_d, o_valid_d} !== {32'hA500_0080, 10'h080, 10'h084, 1'b1}) begin errors++; $display("FAIL rr_ifid got %h exp %h", {o_instr_d, o_pc_d, o_pc4_d, o_valid_d}, {32'hA500_0080, 10'h080, 10'h084, 1'b1}); end
    endtask

    task automatic test_flush();
        step();
        i_flush_d = 1'b1;
        step();
        i_flush_d = 1'b0;
        checks++; if ({o_instr_d, o_pc_d, o_pc4_d, o_valid_d} !== {32'h0000_0013, 10'h000, 10'h000, 1'b0}) begin errors++; $display("FAIL fl_ifid got %h exp %h", {o_instr_d, o_pc_d, o_pc4_d, o_valid_d}, {32'h0000_0013, 10'h000, 10'h000, 1'b0}); end
        checks++; if ({o_imem_req, o_imem_addr} !== {1'b1, 10'h088}) begin errors++; $display("FAIL fl_pc_adv got %h exp %h", {o_imem_req, o_imem_addr}, {1'b1, 10'h088}); end
        step(); step();
        checks++; if ({o_instr_d, o_pc_d, o_pc4_d, o_valid_d} !== {32'hA500_0088, 10'h088, 10'h08C, 1'b1}) begin errors++; $display("FAIL fl_next got %h exp %h", {o_instr_d, o_pc_d, o_pc4_d, o_valid_d}, {32'hA500_0088, 10'h088, 10'h08C, 1'b1}); end
    endtask

    task automatic test_wrap();
        i_pcsrc_e = 1'b1; i_pc_target_e = 10'h3FC;
        step();
        i_pcsrc_e = 1'b0;
        step();
        checks++; if ({o_imem_req, o_imem_addr} !== {1'b1, 10'h3FC}) begin errors++; $display("FAIL wr_req got %h exp %h", {o_imem_req, o_imem_addr}, {1'b1, 10'h3FC}); end
        step(); step();
        checks++; if ({o_instr_d, o_pc_d, o_pc4_d, o_valid_d} !== {32'hA500_03FC, 10'h3FC, 10'h000, 1'b1}) begin errors++; $display("FAIL wr_ifid got %h exp %h", {o_instr_d, o_pc_d, o_pc4_d, o_valid_d}, {32'hA500_03FC, 10'h3FC, 10'h000, 1'b1}); end
        checks++; if ({o_imem_req, o_imem_addr} !== {1'b1, 10'h000}) begin errors++; $display("FAIL wr_next_req got %h exp %h", {o_imem_req, o_imem_addr}, {1'b1, 10'h000}); end
    endtask

    task automatic test_reset_mid();
        mem_lat = 3; i_stall_d = 1'b1;
        step();
        checks++; if ({o_instr_d, o_pc_d, o_pc4_d, o_valid_d, o_imem_req} !== {32'hA500_03FC, 10'h3FC, 10'h000, 1'b1, 1'b0}) begin errors++; $display("FAIL rm_pre got %h exp %h", {o_instr_d, o_pc_d, o_pc4_d, o_valid_d, o_imem_req}, {32'hA500_03FC, 10'h3FC, 10'h000, 1'b1, 1'b0}); end
        i_rst = 1'b1;
        #1;
        checks++; if ({o_instr_d, o_pc_d, o_pc4_d, o_valid_d, o_imem_req} !== {32'h0000_0013, 10'h000, 10'h000, 1'b0, 1'b0}) begin errors++; $display("FAIL rm_async got %h exp %h", {o_instr_d, o_pc_d, o_pc4_d, o_valid_d, o_imem_req}, {32'h0000_0013, 10'h000, 10'h000, 1'b0, 1'b0}); end
        i_stall_d = 1'b0; mem_lat = 1;
        step();
        i_rst = 1'b0;
        #1;
        checks++; if ({o_imem_req, o_imem_addr} !== {1'b1, 10'h000}) begin errors++; $display("FAIL rm_rel_req got %h exp %h", {o_imem_req, o_imem_addr}, {1'b1, 10'h000}); end
        step();
        checks++; if ({o_imem_req, o_valid_d} !== 2'b00) begin errors++; $display("FAIL rm_wait got %b exp 00", {o_imem_req, o_valid_d}); end
        step();
        checks++; if ({o_instr_d, o_pc_d, o_pc4_d, o_valid_d} !== {32'h0050_0093, 10'h000, 10'h004, 1'b1}) begin errors++; $display("FAIL rm_refetch got %h exp %h", {o_instr_d, o_pc_d, o_pc4_d, o_valid_d}, {32'h0050_0093, 10'h000, 10'h004, 1'b1}); end
    endtask

    initial begin
        test_reset();
        test_first_fetch();
        test_stall();
        test_redirect_wait();
        test_redirect_req();
        test_flush();
        test_wrap();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
